// File: rtl/mlab_bist_pkg.sv
// Shared definitions for the MLAB March C- BIST controller.
// Holds the FSM state type and the per-element constant tables.
// Table bit e describes march element Me (bit 0 = M0 ... bit 5 = M5).
package mlab_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_ELEM = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

  //                                   M5 M4 M3 M2 M1 M0
  // Element walks addresses N-1 .. 0
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN = 6'b0_1_1_0_0_0;
  // Element compares the old word before writing
  localparam logic [NUM_ELEM-1:0] ELEM_RD   = 6'b1_1_1_1_1_0;
  // Background bit expected on the read
  localparam logic [NUM_ELEM-1:0] ELEM_RBIT = 6'b0_1_0_1_0_0;
  // Element writes a new word
  localparam logic [NUM_ELEM-1:0] ELEM_WE   = 6'b0_1_1_1_1_1;
  // Background bit written
  localparam logic [NUM_ELEM-1:0] ELEM_WBIT = 6'b0_0_1_0_1_0;

endpackage

// File: rtl/mlab_bist_addr_gen.sv
// Loadable up/down address counter for the march sequencer.
// last_o flags the final address of the current direction by compare,
// so the element boundary never depends on counter wrap.
module mlab_bist_addr_gen #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  load_down_i,
  input  logic                  step_i,
  input  logic                  down_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next address: load a direction's start point, or step one word
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? ADDR_MAX : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
    end
  end

  // Address register; holds its value whenever the march is not stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/mlab_march_bist.sv
// March C- BIST controller for one async-read / sync-write MLAB RAM.
// Each RUN cycle presents one address, compares the old word read
// combinationally, and writes the new word at the closing edge.
// Optional build macro MLAB_BIST_ERR_COUNT_EN adds a saturating
// 16-bit err_count of every mismatching read cycle.
module mlab_march_bist
  import mlab_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_xor
`ifdef MLAB_BIST_ERR_COUNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pass_q, pass_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_xor_q, fail_xor_d;

  logic                  gen_load, gen_load_down, gen_step, gen_last;
  logic [2:0]            elem_next;
  logic                  launch, mismatch;
  logic [DATA_WIDTH-1:0] exp_word, diff_word;

  mlab_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (gen_load),
    .load_down_i (gen_load_down),
    .step_i      (gen_step),
    .down_i      (ELEM_DOWN[elem_q]),
    .addr_o      (mem_addr),
    .last_o      (gen_last)
  );

  assign elem_next = elem_q + 3'd1;
  assign launch    = (state_q != ST_RUN) && start;
  assign exp_word  = {DATA_WIDTH{ELEM_RBIT[elem_q]}};
  assign diff_word = mem_rdata ^ exp_word;
  assign mismatch  = (state_q == ST_RUN) && ELEM_RD[elem_q] && (diff_word != '0);

  // State and registered outputs; reset aborts any march in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      elem_q      <= 3'd0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      pass_q      <= 1'b1;
      fail_elem_q <= 3'd0;
      fail_addr_q <= '0;
      fail_xor_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      pass_q      <= pass_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_xor_q  <= fail_xor_d;
    end
  end

  // Next state: sequence elements back to back, no bubble between them
  always_comb begin
    state_d       = state_q;
    elem_d        = elem_q;
    gen_load      = 1'b0;
    gen_load_down = 1'b0;
    gen_step      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_RUN;
          elem_d        = 3'd0;
          gen_load      = 1'b1;
          gen_load_down = ELEM_DOWN[0];
        end
      end
      ST_RUN: begin
        if (gen_last) begin
          if (elem_q == LAST_ELEM) begin
            state_d = ST_DONE;
          end else begin
            elem_d        = elem_next;
            gen_load      = 1'b1;
            gen_load_down = ELEM_DOWN[elem_next];
          end
        end else begin
          gen_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: status decode, next write command, first-mismatch capture
  always_comb begin
    busy        = (state_q == ST_RUN);
    done        = (state_q == ST_DONE);
    we_d        = 1'b0;
    wdata_d     = '0;
    pass_d      = pass_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_xor_d  = fail_xor_q;
    if (state_d == ST_RUN) begin
      we_d    = ELEM_WE[elem_d];
      wdata_d = {DATA_WIDTH{ELEM_WBIT[elem_d]}};
    end
    if (launch) begin
      pass_d      = 1'b1;
      fail_elem_d = 3'd0;
      fail_addr_d = '0;
      fail_xor_d  = '0;
    end else if (mismatch && pass_q) begin
      pass_d      = 1'b0;
      fail_elem_d = elem_q;
      fail_addr_d = mem_addr;
      fail_xor_d  = diff_word;
    end
  end

  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign pass      = pass_q;
  assign fail_elem = fail_elem_q;
  assign fail_addr = fail_addr_q;
  assign fail_xor  = fail_xor_q;

`ifdef MLAB_BIST_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count every mismatching read, saturating; restarted by each launch
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (launch)                              err_cnt_d = 16'd0;
    else if (mismatch && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 16'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mlab_march_bist.sv
// Bench for mlab_march_bist: a faulty-RAM model beside the DUT, and a
// march model that replays March C- over an array to predict every
// cycle's address/write command and the final pass/fail capture.
module tb_mlab_march_bist;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } op_t;

  logic clk;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, busy, done, pass;
  logic [2:0]    fail_elem;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_xor;

  logic [1:0]    mem_addr_s;
  logic [3:0]    mem_wdata_s, mem_rdata_s;
  logic          mem_we_s, busy_s, done_s, pass_s;
  logic [2:0]    fail_elem_s;
  logic [1:0]    fail_addr_s;
  logic [3:0]    fail_xor_s;
`ifdef MLAB_BIST_ERR_COUNT_EN
  logic [15:0]   err_count, err_count_s;
`endif

  // RAM models with per-word stuck-at masks
  logic [DW-1:0] ram [N];
  logic [DW-1:0] sa1 [N];
  logic [DW-1:0] sa0 [N];
  logic [3:0]    ram_s [4];

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;
  bit mon_en = 1'b0;
  op_t exp_q[$];
  int  log_a[$];
  int  log_w[$];

  bit            m_pass;
  int            m_elem, m_addr, m_cnt;
  logic [DW-1:0] m_xor;

  mlab_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_xor(fail_xor)
`ifdef MLAB_BIST_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  mlab_march_bist #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_we(mem_we_s),
    .mem_rdata(mem_rdata_s), .busy(busy_s), .done(done_s), .pass(pass_s),
    .fail_elem(fail_elem_s), .fail_addr(fail_addr_s), .fail_xor(fail_xor_s)
`ifdef MLAB_BIST_ERR_COUNT_EN
    , .err_count(err_count_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata   = (ram[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  assign mem_rdata_s = ram_s[mem_addr_s];

  always @(posedge clk) begin
    if (mem_we)   ram[mem_addr]     <= mem_wdata;
    if (mem_we_s) ram_s[mem_addr_s] <= mem_wdata_s;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Replay March C- over a plain array (with the same stuck-at faults)
  task automatic build_model();
    logic [DW-1:0] m [N];
    logic [DW-1:0] rd, ex;
    int a;
    bit down, rb, wb;
    op_t o;
    exp_q.delete();
    m_pass = 1'b1; m_elem = 0; m_addr = 0; m_xor = '0; m_cnt = 0;
    for (int e = 0; e < 6; e++) begin
      down = (e == 3) || (e == 4);
      rb   = (e == 2) || (e == 4);
      wb   = (e == 1) || (e == 3);
      for (int i = 0; i < N; i++) begin
        a = down ? (N - 1 - i) : i;
        if (e != 0) begin
          rd = (m[a] | sa1[a]) & ~sa0[a];
          ex = rb ? '1 : '0;
          if (rd !== ex) begin
            if (m_pass) begin
              m_elem = e; m_addr = a; m_xor = rd ^ ex;
            end
            m_pass = 1'b0;
            m_cnt++;
          end
        end
        if (e != 5) m[a] = wb ? '1 : '0;
        o.addr  = AW'(a);
        o.we    = (e != 5);
        o.wdata = wb ? '1 : '0;
        exp_q.push_back(o);
      end
    end
  endtask

  // Per-cycle compare against the model's op stream; also logs the small DUT
  task automatic compare_loop();
    op_t o;
    int step;
    step = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (busy_s === 1'b1) begin
        log_a.push_back(int'(mem_addr_s));
        log_w.push_back(int'(mem_we_s));
      end
      if (mon_en && exp_q.size() > 0) begin
        o = exp_q.pop_front();
        step++;
        n_tests++;
        if (busy !== 1'b1 || mem_addr !== o.addr || mem_we !== o.we ||
            (o.we && mem_wdata !== o.wdata)) begin
          n_fail++;
          $display("FAIL step%0d: busy=%0b addr=%0d we=%0b wdata=%h, required busy=1 addr=%0d we=%0b wdata=%h",
                   step, busy, mem_addr, mem_we, mem_wdata, o.addr, o.we, o.wdata);
        end
      end
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin
      sa1[i] = '0;
      sa0[i] = '0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 1);
    chk({tag, "_fail_elem"}, fail_elem, 0);
    chk({tag, "_fail_addr"}, fail_addr, 0);
    chk({tag, "_fail_xor"}, fail_xor, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // One full march; pulse_at re-asserts start mid-run, reset_at aborts
  task automatic run_march(input string tag, input int pulse_at, input int reset_at);
    int c;
    mon_en = 1'b0;
    build_model();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    busy_cnt = 0;
    mon_en = 1'b1;
    c = 0;
    while (exp_q.size() > 0 && c < 6 * N + 20) begin
      @(posedge clk); #1;
      c++;
      start = (c == pulse_at);
      if (c == reset_at) begin
        #2 rst_n = 1'b0;
        #1 mon_en = 1'b0;
        exp_q.delete();
        check_reset_values({tag, "_async_rst"});
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    chk({tag, "_timeout_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    chk({tag, "_busy_cycles"}, busy_cnt, 6 * N);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pass"}, pass, m_pass);
    chk({tag, "_fail_elem"}, fail_elem, m_pass ? 0 : m_elem);
    chk({tag, "_fail_addr"}, fail_addr, m_pass ? 0 : m_addr);
    chk({tag, "_fail_xor"}, fail_xor, m_pass ? 0 : m_xor);
    chk({tag, "_idle_we"}, mem_we, 0);
    chk({tag, "_idle_wdata"}, mem_wdata, 0);
`ifdef MLAB_BIST_ERR_COUNT_EN
    chk({tag, "_err_count"}, err_count, m_cnt);
`endif
  endtask

  initial begin
    int nz, fa, fb, c;
    int exp_seq[24];
    clear_faults();
    fork
      compare_loop();
    join_none

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fault-free march; RAM must end all zeros
    run_march("clean", 0, 0);
    chk("clean_pass_lit", pass, 1);
    chk("clean_xor_lit", fail_xor, 8'h00);
    nz = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== 8'h00) nz++;
    chk("clean_ram_nonzero_words", nz, 0);

    // Stuck-at-1 on bit 3 of address 5, with an ignored mid-run start
    sa1[5] = 8'h08;
    run_march("sa1", 100, 0);
    chk("sa1_pass_lit", pass, 0);
    chk("sa1_elem_lit", fail_elem, 1);
    chk("sa1_addr_lit", fail_addr, 5);
    chk("sa1_xor_lit", fail_xor, 8'h08);
    chk("sa1_model_cnt", m_cnt, 3);
    clear_faults();

    // Second start from DONE clears the capture
    run_march("rerun", 0, 0);
    chk("rerun_addr_lit", fail_addr, 0);

    // Stuck-at-0 on bit 0 of address 63
    sa0[63] = 8'h01;
    run_march("sa0", 0, 0);
    chk("sa0_elem_lit", fail_elem, 2);
    chk("sa0_addr_lit", fail_addr, 63);
    chk("sa0_xor_lit", fail_xor, 8'h01);
    chk("sa0_model_cnt", m_cnt, 2);
    clear_faults();

    // Reset at cycle 200, then a full run
    run_march("abort", 0, 200);
    run_march("after_abort", 0, 0);

    // Randomized faults and stray start pulses
    for (int k = 0; k < 4; k++) begin
      clear_faults();
      fa = $urandom_range(N - 1);
      fb = $urandom_range(N - 1);
      if ($urandom_range(1) == 1) sa1[fa] = 8'(1 << $urandom_range(7));
      else                        sa0[fa] = 8'(1 << $urandom_range(7));
      if ($urandom_range(1) == 1) sa1[fb] = sa1[fb] | 8'(1 << $urandom_range(7));
      run_march($sformatf("rnd%0d", k), int'($urandom_range(6 * N - 2, 1)), 0);
    end
    clear_faults();

    // Small instance: address order and write enables per cycle
    exp_seq = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 3,2,1,0, 3,2,1,0, 0,1,2,3};
    log_a.delete();
    log_w.delete();
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    c = 0;
    while (done_s !== 1'b1 && c < 60) begin
      @(posedge clk); #1;
      c++;
    end
    chk("small_done", done_s, 1);
    chk("small_pass", pass_s, 1);
    chk("small_log_len", log_a.size(), 24);
    if (log_a.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        chk($sformatf("small_addr%0d", i), log_a[i], exp_seq[i]);
        chk($sformatf("small_we%0d", i), log_w[i], (i < 20) ? 1 : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mlab_march_bist.md
Name: mlab_march_bist

Overview:
- Built-in self-test controller that drives one async-read / sync-write single-port RAM (MLAB style) through a March C- sequence.
- Owns the RAM's addr, data_in and write pins. Samples data_out combinationally in the same cycle the address is presented.
- Reports pass/fail and captures the first failing location.
- Sits beside each inferred RAM in the memory test benchmarks and replaces testbench-only checking.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 6, RAM address width; depth N = 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launches a test when sampled high in IDLE or DONE.
- mem_addr  output  ADDR_WIDTH  to RAM addr.
- mem_wdata  output  DATA_WIDTH  to RAM data_in.
- mem_we  output  1  to RAM write.
- mem_rdata  input  DATA_WIDTH  from RAM data_out (async read).
- busy  output  1  high while a march is running.
- done  output  1  high in DONE; held until next start or reset.
- pass  output  1  valid when done=1; 1 means no mismatch was seen.
- fail_elem  output  3  march element index (0..5) of the first mismatch.
- fail_addr  output  ADDR_WIDTH  address of the first mismatch.
- fail_xor  output  DATA_WIDTH  mem_rdata XOR expected, captured at the first mismatch.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0 except pass=1; fail_* = 0. Reset mid-march aborts immediately; the RAM contents are left undefined.
- States: IDLE, RUN, DONE. Element counter e runs 0..5; address counter a.
- March elements, one address per cycle:
  - M0 up: w0
  - M1 up: r0,w1
  - M2 up: r1,w0
  - M3 down: r0,w1
  - M4 down: r1,w0
  - M5 up: r0
  - "0" = all-zeros word; "1" = all-ones word.
- Read-then-write in one cycle: in cycle with mem_addr=a, compare mem_rdata (old contents) against the expected value. mem_we and mem_wdata carry the new value, which is written at the closing posedge.
  - M0 compares nothing.
  - M5 holds mem_we=0.
- Up elements start at a=0 and end at N-1. Down elements start at a=N-1 and end at 0. The element change occurs on the edge after the last address, with no bubble cycle.
- Start and timing:
  - start sampled in IDLE/DONE at edge E0 → RUN. From E0: busy=1, done=0, pass=1, fail_* cleared.
  - busy spans exactly 6N cycles.
  - After the last M5 cycle → DONE: busy=0, done=1.
- start is ignored while busy=1.
- Mismatch handling:
  - The first mismatch sets pass=0 and captures fail_elem, fail_addr and fail_xor.
  - Later mismatches do not overwrite the capture.
  - The march always runs to completion.
- mem_addr, mem_wdata and mem_we are registered. In IDLE/DONE, mem_we=0, mem_addr holds its last value and mem_wdata=0.
- Widths: the address counter is ADDR_WIDTH bits; end-of-element is detected by compare, not by wrap. The expected word is the background bit replicated to DATA_WIDTH.

Optional Feature:
- MLAB_BIST_ERR_COUNT_EN defined:
  - Adds output err_count, 16 bits. Counts every mismatching read cycle; saturates at 16'hFFFF.
  - Cleared on reset and on start.
- MLAB_BIST_ERR_COUNT_EN undefined: the port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package mlab_bist_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - NUM_ELEM=6
  - per-element constant tables: direction (up/down), read-enable, expected bit, write-enable, write bit.
- One sub-module: mlab_bist_addr_gen. It is an up/down loadable ADDR_WIDTH counter with a last_addr flag, driven by the element direction.

Test Plan:
- Fault-free RAM, defaults, start pulse → busy high exactly 384 cycles; done=1, pass=1, fail_xor=0; final RAM contents all 8'h00.
- Bit 3 of addr 5 stuck-at-1 → pass=0, fail_elem=1, fail_addr=5, fail_xor=8'h08.
- Bit 0 of addr 63 stuck-at-0 → pass=0, fail_elem=2, fail_addr=63, fail_xor=8'h01. With MLAB_BIST_ERR_COUNT_EN: err_count=2 (M2 and M4 reads).
- start pulsed again mid-run (cycle 100) → ignored; busy still drops at cycle 384. A second start in DONE re-runs and clears the fail_* capture.
- rst_n asserted at cycle 200 → outputs return to reset values immediately (asynchronously, not at the next edge). A new start runs the full 384 cycles.
- ADDR_WIDTH=2, DATA_WIDTH=4; scoreboard logs mem_addr per cycle → sequence 0,1,2,3 ×3 then 3,2,1,0 ×2 then 0,1,2,3; mem_we=0 only in the last 4 cycles.
